alu_arbiter: RTL and testbench

- Shares one registered ALU between two requesters.
- Each requester presents operands A, B and an opcode over a valid/ready handshake.
- A round-robin arbiter grants one request at a time, drives the ALU inputs, waits the ALU latency, and returns R/flag tagged with the requester id.
- Sits between the operand generators and the `alu` instance in the top level, replacing the direct generator-to-ALU connection.

---
 rtl/alu_arbiter_if.sv | 55 +++++
 rtl/alu_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two operand generators, the arbiter and the shared ALU.
// Handshake: a request transfers on a rising edge where reqN_valid && reqN_ready;
// the requester holds valid and operands stable until that edge. rsp_valid is a
// single-cycle pulse with no backpressure.
`timescale 1ns/1ps

interface alu_arbiter_if #(
  parameter int data_width = 32
);
  // requester 0
  logic                         req0_valid;
  logic                         req0_ready;
  logic signed [data_width-1:0] req0_A;
  logic signed [data_width-1:0] req0_B;
  logic [3:0]                   req0_op;
  // requester 1
  logic                         req1_valid;
  logic                         req1_ready;
  logic signed [data_width-1:0] req1_A;
  logic signed [data_width-1:0] req1_B;
  logic [3:0]                   req1_op;
  // shared ALU
  logic signed [data_width-1:0] alu_A;
  logic signed [data_width-1:0] alu_B;
  logic [3:0]                   alu_op;
  logic signed [data_width-1:0] alu_R;
  logic                         alu_flag;
  // response
  logic                         rsp_valid;
  logic                         rsp_id;
  logic signed [data_width-1:0] rsp_R;
  logic                         rsp_flag;

  // arbiter side
  modport slave (
    input  req0_valid, req0_A, req0_B, req0_op,
    output req0_ready,
    input  req1_valid, req1_A, req1_B, req1_op,
    output req1_ready,
    output alu_A, alu_B, alu_op,
    input  alu_R, alu_flag,
    output rsp_valid, rsp_id, rsp_R, rsp_flag
  );

  // environment side: requesters, ALU and response consumer
  modport master (
    output req0_valid, req0_A, req0_B, req0_op,
    input  req0_ready,
    output req1_valid, req1_A, req1_B, req1_op,
    input  req1_ready,
    input  alu_A, alu_B, alu_op,
    output alu_R, alu_flag,
    input  rsp_valid, rsp_id, rsp_R, rsp_flag
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// One operation is in flight at a time: IDLE grants and issues operands, WAIT
// counts out the ALU latency and captures the result tagged with the owner id.
// Handshake: a request transfers on a rising edge where reqN_valid && reqN_ready;
// ready is only raised in IDLE, out of reset, for the granted requester.
// alu_latency must lie in 1..7 (the wait counter is three bits wide).
`timescale 1ns/1ps

module alu_arbiter #(
  parameter int data_width  = 32,
  parameter int alu_latency = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic          dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [2:0] lat_count = 3'(alu_latency);

  state_t state;
  state_t state_next;

  logic [2:0] counter;
  logic       last_grant;
  logic       owner_id;

  logic       grant_any;
  logic       grant_id;
  logic       accept;
  logic       capture;

  logic signed [data_width-1:0] sel_A;
  logic signed [data_width-1:0] sel_B;
  logic [3:0]                   sel_op;

  assign dbg_state = logic'(state);

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_A  = bus.req0_A;
    sel_B  = bus.req0_B;
    sel_op = bus.req0_op;
    if (grant_id) begin
      sel_A  = bus.req1_A;
      sel_B  = bus.req1_B;
      sel_op = bus.req1_op;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, ready outputs, accept/capture strobes.
  always_comb begin
    state_next     = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    accept         = 1'b0;
    capture        = 1'b0;
    case (state)
      IDLE: begin
        // Ready is raised only toward a requester that is valid, so a raised
        // ready always completes a handshake at the next edge.
        if (rst && grant_any) begin
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          accept         = 1'b1;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        if (counter == lat_count) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latency counter: cleared on issue, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      counter <= 3'd0;
    end else if (accept) begin
      counter <= 3'd0;
    end else if (state == WAIT) begin
      counter <= counter + 3'd1;
    end
  end

  // Issue: register the winner's operands toward the ALU and remember the owner.
  // The ALU keeps seeing the last operands while idle; those results are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.alu_A  <= '0;
      bus.alu_B  <= '0;
      bus.alu_op <= 4'd0;
      owner_id   <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      bus.alu_A  <= sel_A;
      bus.alu_B  <= sel_B;
      bus.alu_op <= sel_op;
      owner_id   <= grant_id;
      last_grant <= grant_id;
    end
  end

  // Response: one-cycle valid pulse; captured fields hold until the next capture.
  // A reset during WAIT drops the in-flight operation without a response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_R     <= '0;
      bus.rsp_flag  <= 1'b0;
    end else begin
      bus.rsp_valid <= capture;
      if (capture) begin
        bus.rsp_id   <= owner_id;
        bus.rsp_R    <= bus.alu_R;
        bus.rsp_flag <= bus.alu_flag;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a latency-1 instance and a latency-3 instance,
// each driving a bench ALU stub (op 0: A+B, op 1: A-B, flag = result==0).
`timescale 1ns/1ps

module tb_alu_arbiter;

  logic clk;
  logic rst;
  logic dbg1;
  logic dbg3;
  int   checks;
  int   errors;

  alu_arbiter_if #(.data_width(32)) b  ();
  alu_arbiter_if #(.data_width(32)) b3 ();

  alu_arbiter #(.data_width(32), .alu_latency(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (b),
    .dbg_state (dbg1)
  );

  alu_arbiter #(.data_width(32), .alu_latency(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .bus       (b3),
    .dbg_state (dbg3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- ALU stubs ----------------
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] bb,
                                        input logic [3:0] op);
    if (op == 4'd1) return a - bb;
    return a + bb;
  endfunction

  always @(posedge clk) begin
    b.alu_R    <= alu_f(b.alu_A, b.alu_B, b.alu_op);
    b.alu_flag <= (alu_f(b.alu_A, b.alu_B, b.alu_op) == 32'd0);
  end

  logic [31:0] p1_r, p2_r;
  always @(posedge clk) begin
    p1_r        <= alu_f(b3.alu_A, b3.alu_B, b3.alu_op);
    p2_r        <= p1_r;
    b3.alu_R    <= p2_r;
    b3.alu_flag <= (p2_r == 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    b.req0_valid = 1'b0;  b.req1_valid = 1'b0;
    b3.req0_valid = 1'b0; b3.req1_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    b.req0_valid = 1'b1; b.req0_A = 32'd11; b.req0_B = 32'd22; b.req0_op = 4'd0;
    b.req1_valid = 1'b1; b.req1_A = 32'd33; b.req1_B = 32'd44; b.req1_op = 4'd1;
    b3.req0_valid = 1'b0; b3.req1_valid = 1'b0;
    b3.req0_A = '0; b3.req0_B = '0; b3.req0_op = '0;
    b3.req1_A = '0; b3.req1_B = '0; b3.req1_op = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (b.req0_ready !== 1'b0 || b.req1_ready !== 1'b0) begin
        errors++; $display("FAIL reset_ready cyc %0d got %b%b want 00", i, b.req0_ready, b.req1_ready);
      end
      checks++;
      if (b.rsp_valid !== 1'b0 || b.rsp_id !== 1'b0 || b.rsp_flag !== 1'b0 || b.rsp_R !== 32'd0) begin
        errors++; $display("FAIL reset_rsp cyc %0d got v=%b id=%b f=%b R=%0d want zeros", i,
                           b.rsp_valid, b.rsp_id, b.rsp_flag, b.rsp_R);
      end
      checks++;
      if (b.alu_A !== 32'd0 || b.alu_B !== 32'd0 || b.alu_op !== 4'd0 || dbg1 !== 1'b0) begin
        errors++; $display("FAIL reset_alu cyc %0d got A=%0d B=%0d op=%0d st=%b want zeros", i,
                           b.alu_A, b.alu_B, b.alu_op, dbg1);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (b.req0_ready !== 1'b1 || b.req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_first_grant got %b%b want 10", b.req0_ready, b.req1_ready);
    end
    idle_inputs();
  endtask

  task automatic test_single();
    b.req0_A = 32'sd5; b.req0_B = 32'sd7; b.req0_op = 4'd0; b.req0_valid = 1'b1;
    #1;
    checks++;
    if (b.req0_ready !== 1'b1 || b.req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_grant got %b%b want 10", b.req0_ready, b.req1_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      b.req0_valid = 1'b0;
      checks++;
      if (b.rsp_valid !== (k == 3) || b.req1_ready !== 1'b0) begin
        errors++; $display("FAIL single_timing k=%0d got v=%b r1=%b want v=%b r1=0", k,
                           b.rsp_valid, b.req1_ready, (k == 3));
      end
      if (k == 1) begin
        checks++;
        if (dbg1 !== 1'b1 || b.alu_A !== 32'sd5 || b.alu_B !== 32'sd7 || b.alu_op !== 4'd0) begin
          errors++; $display("FAIL single_issue got st=%b A=%0d B=%0d op=%0d want 1 5 7 0",
                             dbg1, b.alu_A, b.alu_B, b.alu_op);
        end
      end
      if (k >= 3) begin
        checks++;
        if (b.rsp_R !== 32'sd12 || b.rsp_flag !== 1'b0 || b.rsp_id !== 1'b0) begin
          errors++; $display("FAIL single_result k=%0d got R=%0d f=%b id=%b want 12 0 0", k,
                             $signed(b.rsp_R), b.rsp_flag, b.rsp_id);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp_r;
    logic        exp_f;
    logic        exp_id;
    apply_reset();
    b.req0_A = 32'sd3;  b.req0_B = 32'sd3; b.req0_op = 4'd1; b.req0_valid = 1'b1;
    b.req1_A = -32'sd4; b.req1_B = 32'sd1; b.req1_op = 4'd0; b.req1_valid = 1'b1;
    #1;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (b.req0_ready !== (c % 3 == 0 && (c / 3) % 2 == 0) ||
          b.req1_ready !== (c % 3 == 0 && (c / 3) % 2 == 1)) begin
        errors++; $display("FAIL contention_ready c=%0d got %b%b", c, b.req0_ready, b.req1_ready);
      end
      checks++;
      if (b.rsp_valid !== (c % 3 == 0 && c > 0)) begin
        errors++; $display("FAIL contention_rsp_valid c=%0d got %b want %b", c, b.rsp_valid,
                           (c % 3 == 0 && c > 0));
      end
      if (c % 3 == 0 && c > 0) begin
        exp_id = ((c / 3 - 1) % 2 == 1);
        exp_r  = exp_id ? -32'sd3 : 32'sd0;
        exp_f  = ~exp_id;
        checks++;
        if (b.rsp_id !== exp_id || b.rsp_R !== exp_r || b.rsp_flag !== exp_f) begin
          errors++; $display("FAIL contention_result c=%0d got id=%b R=%0d f=%b want id=%b R=%0d f=%b",
                             c, b.rsp_id, $signed(b.rsp_R), b.rsp_flag, exp_id, $signed(exp_r), exp_f);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_t [4];
    logic [31:0] b_t [4];
    logic [3:0]  op_t [4];
    logic [31:0] r_t [4];
    logic        f_t [4];
    int          idx;
    a_t[0] = 32'sd10;  b_t[0] = 32'sd3;  op_t[0] = 4'd1; r_t[0] = 32'sd7;   f_t[0] = 1'b0;
    a_t[1] = 32'sd2;   b_t[1] = -32'sd2; op_t[1] = 4'd0; r_t[1] = 32'sd0;   f_t[1] = 1'b1;
    a_t[2] = -32'sd8;  b_t[2] = -32'sd8; op_t[2] = 4'd0; r_t[2] = -32'sd16; f_t[2] = 1'b0;
    a_t[3] = 32'sd100; b_t[3] = 32'sd1;  op_t[3] = 4'd1; r_t[3] = 32'sd99;  f_t[3] = 1'b0;
    @(negedge clk);
    b.req1_A = a_t[0]; b.req1_B = b_t[0]; b.req1_op = op_t[0]; b.req1_valid = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) @(negedge clk);
      if (c > 0 && (c - 1) % 3 == 0 && c <= 10) begin
        idx = (c - 1) / 3 + 1;
        if (idx < 4) begin
          b.req1_A = a_t[idx]; b.req1_B = b_t[idx]; b.req1_op = op_t[idx];
        end else begin
          b.req1_valid = 1'b0;
        end
      end
      #1;
      checks++;
      if (b.req1_ready !== (c % 3 == 0 && c <= 9) || b.req0_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_ready c=%0d got r0=%b r1=%b want r0=0 r1=%b", c,
                           b.req0_ready, b.req1_ready, (c % 3 == 0 && c <= 9));
      end
      checks++;
      if (b.rsp_valid !== (c % 3 == 0 && c > 0)) begin
        errors++; $display("FAIL b2b_rsp_valid c=%0d got %b want %b", c, b.rsp_valid,
                           (c % 3 == 0 && c > 0));
      end
      if (c % 3 == 0 && c > 0) begin
        idx = c / 3 - 1;
        checks++;
        if (b.rsp_id !== 1'b1 || b.rsp_R !== r_t[idx] || b.rsp_flag !== f_t[idx]) begin
          errors++; $display("FAIL b2b_result op=%0d got id=%b R=%0d f=%b want id=1 R=%0d f=%b", idx,
                             b.rsp_id, $signed(b.rsp_R), b.rsp_flag, $signed(r_t[idx]), f_t[idx]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    b.req0_A = 32'sd1; b.req0_B = 32'sd1; b.req0_op = 4'd0; b.req0_valid = 1'b1;
    #1;
    checks++;
    if (b.req0_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_grant got %b want 1", b.req0_ready);
    end
    @(negedge clk);
    b.req0_valid = 1'b0;
    checks++;
    if (dbg1 !== 1'b1) begin
      errors++; $display("FAIL midrst_in_wait got state %b want 1", dbg1);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg1 !== 1'b0 || b.rsp_valid !== 1'b0 || b.alu_A !== 32'd0) begin
      errors++; $display("FAIL midrst_cleared got st=%b v=%b A=%0d want 0 0 0", dbg1, b.rsp_valid, b.alu_A);
    end
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (b.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_no_rsp k=%0d got %b want 0", k, b.rsp_valid);
      end
    end
    b.req0_A = 32'sd9; b.req0_B = 32'sd4; b.req0_op = 4'd1; b.req0_valid = 1'b1;
    b.req1_A = 32'sd1; b.req1_B = 32'sd1; b.req1_op = 4'd0; b.req1_valid = 1'b1;
    #1;
    checks++;
    if (b.req0_ready !== 1'b1 || b.req1_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_regrant got %b%b want 10", b.req0_ready, b.req1_ready);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      idle_inputs();
    end
    checks++;
    if (b.rsp_valid !== 1'b1 || b.rsp_R !== 32'sd5 || b.rsp_id !== 1'b0 || b.rsp_flag !== 1'b0) begin
      errors++; $display("FAIL midrst_result got v=%b R=%0d id=%b f=%b want 1 5 0 0",
                         b.rsp_valid, $signed(b.rsp_R), b.rsp_id, b.rsp_flag);
    end
  endtask

  task automatic test_latency3();
    @(negedge clk);
    b3.req0_A = 32'sd20; b3.req0_B = 32'sd5; b3.req0_op = 4'd1; b3.req0_valid = 1'b1;
    #1;
    checks++;
    if (b3.req0_ready !== 1'b1 || b3.req1_ready !== 1'b0) begin
      errors++; $display("FAIL lat3_grant got %b%b want 10", b3.req0_ready, b3.req1_ready);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      b3.req0_valid = 1'b0;
      checks++;
      if (b3.rsp_valid !== (k == 5)) begin
        errors++; $display("FAIL lat3_timing k=%0d got %b want %b", k, b3.rsp_valid, (k == 5));
      end
      if (k == 5) begin
        checks++;
        if (b3.rsp_R !== 32'sd15 || b3.rsp_flag !== 1'b0 || b3.rsp_id !== 1'b0) begin
          errors++; $display("FAIL lat3_result got R=%0d f=%b id=%b want 15 0 0",
                             $signed(b3.rsp_R), b3.rsp_flag, b3.rsp_id);
        end
      end
    end
    b3.req1_A = -32'sd7; b3.req1_B = 32'sd7; b3.req1_op = 4'd0; b3.req1_valid = 1'b1;
    #1;
    checks++;
    if (b3.req1_ready !== 1'b1 || b3.req0_ready !== 1'b0) begin
      errors++; $display("FAIL lat3_grant1 got %b%b want 01", b3.req0_ready, b3.req1_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      b3.req1_valid = 1'b0;
      checks++;
      if (b3.rsp_valid !== (k == 5)) begin
        errors++; $display("FAIL lat3_timing1 k=%0d got %b want %b", k, b3.rsp_valid, (k == 5));
      end
    end
    checks++;
    if (b3.rsp_R !== 32'sd0 || b3.rsp_flag !== 1'b1 || b3.rsp_id !== 1'b1) begin
      errors++; $display("FAIL lat3_result1 got R=%0d f=%b id=%b want 0 1 1",
                         $signed(b3.rsp_R), b3.rsp_flag, b3.rsp_id);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_reset_mid_op();
    test_latency3();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
